key_debounce: RTL and testbench

Debounce and conditioning stage for a single mechanical push-button, sitting directly upstream of the PIO key slave and driving its one-bit `in_port`. Synchronises the raw pad into the `clk` domain, rejects contact bounce with a counter-qualified state machine, and presents a clean active-high level plus single-cycle press/release strobes. The PIO edge-capture logic then sees exactly one rising edge per physical press.

---
 rtl/key_debounce.sv | 177 +++++++++++++++++
 tb/tb_key_debounce.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button synchroniser, debouncer and press/release/long-press strobe generator
// Optional long-press strobe is built when KEY_LONGPRESS_EN is defined.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int CNT_W           = 26,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_out,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam logic             PAD_RELEASED = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
            $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
        end
        if (LONG_CYCLES < 2) begin : g_bad_long
            $error("key_debounce: LONG_CYCLES must be at least 2");
        end
        if (CNT_W < 2 || CNT_W > 31) begin : g_bad_width
            $error("key_debounce: CNT_W out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_REL   = 2'd0,
        S_PWAIT = 2'd1,
        S_PRS   = 2'd2,
        S_RWAIT = 2'd3
    } state_t;

    logic             sync_1;
    logic             sync_2;
    logic             s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;
    logic             release_nxt;

    // Two-flop synchroniser; s is normalised so that 1 always means pressed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_1 <= PAD_RELEASED;
            sync_2 <= PAD_RELEASED;
        end else begin
            sync_1 <= key_raw;
            sync_2 <= sync_1;
        end
    end

    assign s = sync_2 ^ PAD_RELEASED;

`ifdef KEY_LONGPRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic long_done;
    logic long_done_nxt;
    logic long_nxt;
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
`ifdef KEY_LONGPRESS_EN
        long_nxt      = 1'b0;
        long_done_nxt = long_done;
`endif
        case (state)
            S_REL: begin
                cnt_nxt = '0;
`ifdef KEY_LONGPRESS_EN
                long_done_nxt = 1'b0;
`endif
                if (s) begin
                    state_nxt = S_PWAIT;
                end
            end
            S_PWAIT: begin
                if (!s) begin
                    state_nxt = S_REL;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = S_PRS;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_PRS: begin
                if (!s) begin
                    state_nxt = S_RWAIT;
                    cnt_nxt   = '0;
                end else begin
`ifdef KEY_LONGPRESS_EN
                    // Counting stops once the long strobe has fired for this press.
                    if (!long_done) begin
                        if (cnt == LONG_LAST) begin
                            long_nxt      = 1'b1;
                            long_done_nxt = 1'b1;
                            cnt_nxt       = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_ONE;
                        end
                    end
`else
                    cnt_nxt = '0;
`endif
                end
            end
            S_RWAIT: begin
                if (s) begin
                    state_nxt = S_PRS;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt   = S_REL;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
`ifdef KEY_LONGPRESS_EN
                    long_done_nxt = 1'b0;
`endif
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_REL;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the accepting edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_REL;
            cnt         <= '0;
            key_out     <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_out     <= (state_nxt == S_PRS) || (state_nxt == S_RWAIT);
            key_press   <= press_nxt;
            key_release <= release_nxt;
        end
    end

`ifdef KEY_LONGPRESS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            long_done <= 1'b0;
            key_long  <= 1'b0;
        end else begin
            long_done <= long_done_nxt;
            key_long  <= long_nxt;
        end
    end
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - randomized and directed bench for key_debounce against a run-length reference model
module tb_key_debounce;

    localparam int D  = 8;
    localparam int LG = 40;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic key_raw = 1'b1;
    logic key_out;
    logic key_press;
    logic key_release;
    logic key_long;

    always #5 clk = ~clk;

    key_debounce #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (LG),
        .CNT_W          (8),
        .ACTIVE_LOW     (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_raw    (key_raw),
        .key_out    (key_out),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int n_press = 0;
    int n_rel   = 0;
    int n_long  = 0;

    // Reference: the accepted level flips once the pressed-sense sample has
    // disagreed with it for D+1 consecutive cycles (after a two-sample pad delay).
    bit m_q1 = 1'b1, m_q2 = 1'b1;
    bit m_lvl = 1'b0, m_prev_s = 1'b0, m_ld = 1'b0;
    int m_run = 0, m_lc = 0;
    bit e_out = 1'b0, e_press = 1'b0, e_rel = 1'b0, e_long = 1'b0;

    always @(posedge clk) begin
        bit s, was;
        if (!reset_n) begin
            m_q1 = 1'b1; m_q2 = 1'b1;
            m_lvl = 1'b0; m_prev_s = 1'b0; m_ld = 1'b0;
            m_run = 0; m_lc = 0;
            e_out = 1'b0; e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
        end else begin
            s = ~m_q2;
            was = m_lvl;
            e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
            if (s != m_lvl) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_lvl = s;
                    m_run = 0;
                    if (s) e_press = 1'b1;
                    else begin e_rel = 1'b1; m_ld = 1'b0; end
                end
            end else begin
                m_run = 0;
            end
`ifdef KEY_LONGPRESS_EN
            // Continuous held samples after the press (or after a bounce back) count toward the long threshold.
            if (was && m_lvl && s && m_prev_s) begin
                if (!m_ld) begin
                    m_lc++;
                    if (m_lc == LG) begin e_long = 1'b1; m_ld = 1'b1; m_lc = 0; end
                end
            end else begin
                m_lc = 0;
            end
`else
            m_lc = (was && m_lvl) ? m_lc : 0;
`endif
            e_out = m_lvl;
            m_prev_s = s;
            m_q2 = m_q1;
            m_q1 = key_raw;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (chk_en) begin
            check("model_key_out", {31'd0, key_out}, {31'd0, e_out});
            check("model_key_press", {31'd0, key_press}, {31'd0, e_press});
            check("model_key_release", {31'd0, key_release}, {31'd0, e_rel});
            check("model_key_long", {31'd0, key_long}, {31'd0, e_long});
        end
        n_press += int'(key_press === 1'b1);
        n_rel   += int'(key_release === 1'b1);
        n_long  += int'(key_long === 1'b1);
    endtask

    task automatic wait_for(input int sel, input int max_k, output int k);
        logic sig;
        k = -1;
        for (int i = 1; i <= max_k; i++) begin
            tick();
            sig = (sel == 0) ? key_press : (sel == 1) ? key_release : key_long;
            if (sig === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k, p0, r0, l0, first;
        bit seen_hi, seen_lo;

        reset_n = 1'b0;
        key_raw = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_key_out", {31'd0, key_out}, 32'd0);
        check("reset_key_press", {31'd0, key_press}, 32'd0);
        check("reset_key_release", {31'd0, key_release}, 32'd0);
        check("reset_key_long", {31'd0, key_long}, 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();

        // Clean press
        r0 = n_rel;
        key_raw = 1'b0;
        wait_for(0, 30, k);
        check("press_latency", k, 11);
        check("press_key_out", {31'd0, key_out}, 32'd1);
        check("press_no_release", n_rel - r0, 0);

        // Hold 100 cycles after the press strobe
        l0 = n_long;
        first = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (key_long === 1'b1 && first < 0) first = i;
        end
`ifdef KEY_LONGPRESS_EN
        check("long_latency", first, 40);
        check("long_count", n_long - l0, 1);
`else
        check("long_latency_absent", first, -1);
        check("long_count_absent", n_long - l0, 0);
`endif

        // High glitch while pressed
        seen_lo = 1'b0;
        key_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); if (key_out !== 1'b1) seen_lo = 1'b1; end
        key_raw = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); if (key_out !== 1'b1) seen_lo = 1'b1; end
        check("glitch_high_key_out_held", {31'd0, seen_lo}, 32'd0);

        // Clean release
        p0 = n_press;
        key_raw = 1'b1;
        wait_for(1, 30, k);
        check("release_latency", k, 11);
        check("release_key_out", {31'd0, key_out}, 32'd0);
        check("release_no_press", n_press - p0, 0);

        // Low glitch while released
        p0 = n_press; r0 = n_rel;
        seen_hi = 1'b0;
        key_raw = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(); if (key_out !== 1'b0) seen_hi = 1'b1; end
        key_raw = 1'b1;
        for (int i = 0; i < 20; i++) begin tick(); if (key_out !== 1'b0) seen_hi = 1'b1; end
        check("glitch_low_key_out", {31'd0, seen_hi}, 32'd0);
        check("glitch_low_no_press", n_press - p0, 0);
        check("glitch_low_no_release", n_rel - r0, 0);

        // Bounce: toggle every 3 cycles for 30 cycles, then hold pressed
        p0 = n_press;
        seen_hi = 1'b0;
        for (int seg = 0; seg < 10; seg++) begin
            key_raw = (seg % 2 == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < 3; i++) begin tick(); if (key_out !== 1'b0) seen_hi = 1'b1; end
        end
        check("bounce_key_out_quiet", {31'd0, seen_hi}, 32'd0);
        key_raw = 1'b0;
        wait_for(0, 30, k);
        check("bounce_press_latency", k, 11);
        repeat (20) tick();
        check("bounce_single_press", n_press - p0, 1);
        key_raw = 1'b1;
        repeat (20) tick();

        // Reset mid-qualification at cnt=5 with the key held
        key_raw = 1'b0;
        repeat (8) tick();
        reset_n = 1'b0;
        tick();
        tick();
        check("midreset_key_out", {31'd0, key_out}, 32'd0);
        check("midreset_key_press", {31'd0, key_press}, 32'd0);
        check("midreset_key_release", {31'd0, key_release}, 32'd0);
        p0 = n_press;
        reset_n = 1'b1;
        wait_for(0, 30, k);
        check("post_reset_press_latency", k, 11);
        repeat (5) tick();
        check("post_reset_single_press", n_press - p0, 1);
        key_raw = 1'b1;
        repeat (20) tick();

        // Randomized runs, some long enough to reach the long-press threshold
        for (int seg = 0; seg < 200; seg++) begin
            key_raw = 1'($urandom_range(0, 1));
            k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70)) : int'($urandom_range(1, 12));
            repeat (k) tick();
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
                reset_n = 1'b1;
            end
        end

        key_raw = 1'b1;
        repeat (20) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
